// File: rtl/io_key_handshake_responder.sv
// rtl/io_key_handshake_responder.sv - subiu/desceu I/O key handshake responder
// Optional debounce counter enabled by macro IO_KEY_DEBOUNCE_EN.
module io_key_handshake_responder #(
   parameter int DATA_W          = 16,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_raw,
   input  logic [DATA_W-1:0] switches,
   input  logic              io_req,
   input  logic              io_is_out,
   input  logic [DATA_W-1:0] acc_data,
   output logic              subiu,
   output logic              desceu,
   output logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_UP,
      S_ARMED,
      S_PRESSED,
      S_RELEASED
   } state_t;

   // Synchronizer resets to the raw "released" level so reset never fakes a press.
   localparam logic RAW_RELEASED = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

   logic key_s1, key_s2, key_lvl, key_db;
   logic press_evt, release_evt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_s1 <= RAW_RELEASED;
         key_s2 <= RAW_RELEASED;
      end else begin
         key_s1 <= key_raw;
         key_s2 <= key_s1;
      end
   end

   assign key_lvl = KEY_ACTIVE_LOW ? ~key_s2 : key_s2;

`ifdef IO_KEY_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] db_cnt;
   logic             key_q;

   // Flip on the edge where the count would reach DEBOUNCE_CYCLES.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         db_cnt      <= '0;
         key_q       <= 1'b0;
         press_evt   <= 1'b0;
         release_evt <= 1'b0;
      end else begin
         press_evt   <= 1'b0;
         release_evt <= 1'b0;
         if (key_lvl == key_q) begin
            db_cnt <= '0;
         end else if (db_cnt == CNT_LAST) begin
            key_q       <= key_lvl;
            db_cnt      <= '0;
            press_evt   <= key_lvl;
            release_evt <= ~key_lvl;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign key_db = key_q;
`else
   logic key_q;

   always_ff @(posedge clk) begin
      if (!rst_n) key_q <= 1'b0;
      else        key_q <= key_lvl;
   end

   assign key_db      = key_lvl;
   assign press_evt   = key_lvl & ~key_q;
   assign release_evt = ~key_lvl & key_q;
`endif

   state_t state, state_nxt;
   logic   cap_in, cap_out;

   always_comb begin
      state_nxt = state;
      cap_in    = 1'b0;
      cap_out   = 1'b0;
      case (state)
         S_IDLE: begin
            if (io_req) state_nxt = key_db ? S_WAIT_UP : S_ARMED;
         end
         S_WAIT_UP: begin
            if (!io_req)          state_nxt = S_IDLE;
            else if (release_evt) state_nxt = S_ARMED;
         end
         S_ARMED: begin
            // Abort takes priority over a coincident press: no capture.
            if (!io_req) begin
               state_nxt = S_IDLE;
            end else if (press_evt) begin
               state_nxt = S_PRESSED;
               cap_in    = ~io_is_out;
               cap_out   = io_is_out;
            end
         end
         S_PRESSED: begin
            if (!io_req)          state_nxt = S_IDLE;
            else if (release_evt) state_nxt = S_RELEASED;
         end
         S_RELEASED: begin
            if (!io_req) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         subiu    <= 1'b0;
         desceu   <= 1'b0;
         in_data  <= '0;
         out_data <= '0;
      end else begin
         state  <= state_nxt;
         subiu  <= (state_nxt == S_PRESSED) || (state_nxt == S_RELEASED);
         desceu <= (state_nxt == S_RELEASED);
         if (cap_in)  in_data  <= switches;
         if (cap_out) out_data <= acc_data;
      end
   end

   assign busy = (state != S_IDLE);

endmodule
